apb_reg_bridge: RTL and testbench
=================================

Name: apb_reg_bridge

Overview:
- Upstream front-end of the general-purpose counter top.
- Converts an APB3 slave transfer into the counter's single-cycle native register access: acc_en/wr_en/addr/wdata strobe, rdata return.
- Adds wait states, address decoding with error response, and registered read-data capture. The counter top then sits on a standard SoC peripheral bus.

Parameters:
- ADDR_W, 5, width of paddr_i (byte address; word index = paddr_i[4:2]).
- NUM_REGS, 6, number of implemented word registers; word index >= NUM_REGS is an error.
- RD_LAT, 1, cycles from the acc_en_o strobe to valid rdata_i (legal 0..3).

Ports:
- clk_i  input  1  system clock, rising edge.
- rstn_i  input  1  asynchronous active-low reset.
- psel_i  input  1  APB select.
- penable_i  input  1  APB enable (access phase).
- pwrite_i  input  1  1 = write, 0 = read.
- paddr_i  input  ADDR_W  APB byte address.
- pwdata_i  input  32  write data; only [15:0] is used.
- prdata_o  output  32  read data; zero-extended from 16 bits.
- pready_o  output  1  transfer complete.
- pslverr_o  output  1  error response, valid only when pready_o=1.
- acc_en_o  output  1  one-cycle register access strobe to the counter top.
- wr_en_o  output  1  write qualifier; valid with acc_en_o.
- addr_o  output  3  register word index.
- wdata_o  output  16  register write data.
- rdata_i  input  16  register read data from the counter top.

Behaviour:
- Reset (async, rstn_i=0): state=IDLE.
  - All outputs 0: prdata_o=0, pready_o=0, pslverr_o=0, acc_en_o=0, wr_en_o=0, addr_o=0, wdata_o=0.
  - Wait counter = 0.
- FSM states: IDLE, STROBE, WAIT, DONE. All outputs are registered.
- IDLE:
  - On psel_i=1 and penable_i=0 (setup phase), latch:
    - pwrite_i;
    - addr_o <= paddr_i[4:2];
    - wdata_o <= pwdata_i[15:0].
  - Error when paddr_i[1:0] != 0 or paddr_i[4:2] >= NUM_REGS.
    - On error: go to DONE with pslverr pending. No strobe is ever issued.
  - Otherwise go to STROBE.
- STROBE (exactly 1 cycle):
  - acc_en_o=1; wr_en_o = latched pwrite.
  - Write: next state DONE.
  - Read with RD_LAT=0: capture rdata_i this cycle, then DONE.
  - Read with RD_LAT>0: load counter with RD_LAT, then WAIT.
- WAIT:
  - Decrement counter each cycle.
  - When counter==1, capture rdata_i into the prdata register, then DONE.
- DONE:
  - Drive pready_o=1.
  - pslverr_o = error flag.
  - prdata_o = captured data for an OK read; 0 for writes and for errors.
  - When psel_i and penable_i are both 1 (always true in legal APB), next cycle: pready_o=0, pslverr_o=0, prdata_o=0, state IDLE.
- Latency from the setup cycle to pready_o:
  - write: 2 cycles;
  - read: 2+RD_LAT cycles;
  - error: 1 cycle.
- Back-to-back transfers: IDLE accepts a setup in the cycle right after DONE. No dead cycle beyond the APB setup phase.
- acc_en_o:
  - never high for more than 1 cycle;
  - never high twice per transfer;
  - never high for error transfers.
- addr_o and wdata_o hold their value until the next accepted setup.
- Abort: if psel_i drops while in STROBE, WAIT or DONE, go to IDLE next cycle and clear pready/pslverr.
  - A strobe already issued is not retracted.
  - A strobe not yet issued is never issued.
- Access phase with penable_i=1 while in IDLE (protocol violation): ignored, no strobe.
- pwdata_i[31:16] ignored. Writes ignore rdata_i.
- Reset asserted mid-transfer: all outputs 0 immediately (asynchronous). The transfer is dropped.

Test Plan:
- Write: paddr=0x08, pwdata=0x0000_03FF -> one acc_en_o pulse with wr_en_o=1, addr_o=2, wdata_o=0x03FF; pready_o 2 cycles after setup; pslverr_o=0.
- Read, RD_LAT=1: paddr=0x0C, rdata_i driven to 0x0155 one cycle after the strobe -> prdata_o=0x0000_0155 with pready_o 3 cycles after setup; wr_en_o=0 on the strobe.
- Errors: paddr=0x18 (index 6), then paddr=0x05 (misaligned) -> for each, pready_o and pslverr_o=1 one cycle after setup, prdata_o=0, acc_en_o never asserted.
- Back-to-back: write 0x04 then read 0x04 with no idle cycle -> exactly two strobes; read returns the value the register returns; no missed or extra acc_en_o.
- Abort and reset: psel_i dropped in WAIT -> IDLE next cycle, no pready; rstn_i pulsed low during STROBE -> acc_en_o=0 at once, all outputs 0, next transfer completes normally.
- RD_LAT sweep 0..3 -> read pready_o at 2+RD_LAT cycles after setup, with prdata_o equal to rdata_i sampled RD_LAT cycles after the strobe.

Source files
------------

// File: rtl/apb_reg_bridge.sv
// APB3 slave front-end for the counter top: turns an APB transfer into one
// native register strobe, with address decode errors and RD_LAT-aware read capture.
module apb_reg_bridge #(
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 6,
    parameter int RD_LAT   = 1
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              psel_i,
    input  logic              penable_i,
    input  logic              pwrite_i,
    input  logic [ADDR_W-1:0] paddr_i,
    input  logic [31:0]       pwdata_i,
    output logic [31:0]       prdata_o,
    output logic              pready_o,
    output logic              pslverr_o,
    output logic              acc_en_o,
    output logic              wr_en_o,
    output logic [2:0]        addr_o,
    output logic [15:0]       wdata_o,
    input  logic [15:0]       rdata_i
);

    typedef enum logic [1:0] {IDLE, STROBE, WAIT, DONE} state_e;

    state_e      state_q;
    logic        wr_q;
    logic [1:0]  cnt_q;
    logic [15:0] prdata_q;
    logic        pready_q;
    logic        pslverr_q;
    logic        acc_en_q;
    logic        wr_en_q;
    logic [2:0]  addr_q;
    logic [15:0] wdata_q;
    logic        addr_err;
    logic        unused_ok;

    assign addr_err  = (paddr_i[1:0] != 2'b00) || (32'(paddr_i[4:2]) >= NUM_REGS);
    assign unused_ok = ^pwdata_i[31:16];

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q   <= IDLE;
            wr_q      <= 1'b0;
            cnt_q     <= 2'd0;
            prdata_q  <= 16'd0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            acc_en_q  <= 1'b0;
            wr_en_q   <= 1'b0;
            addr_q    <= 3'd0;
            wdata_q   <= 16'd0;
        end else begin
            acc_en_q <= 1'b0;
            wr_en_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    // Only a setup phase starts a transfer; a stray access phase is ignored.
                    if (psel_i && !penable_i) begin
                        wr_q    <= pwrite_i;
                        addr_q  <= paddr_i[4:2];
                        wdata_q <= pwdata_i[15:0];
                        if (addr_err) begin
                            state_q   <= DONE;
                            pready_q  <= 1'b1;
                            pslverr_q <= 1'b1;
                        end else begin
                            state_q  <= STROBE;
                            acc_en_q <= 1'b1;
                            wr_en_q  <= pwrite_i;
                        end
                    end
                end
                STROBE: begin
                    if (!psel_i) begin
                        state_q <= IDLE;
                    end else if (wr_q) begin
                        state_q  <= DONE;
                        pready_q <= 1'b1;
                    end else if (RD_LAT == 0) begin
                        prdata_q <= rdata_i;
                        state_q  <= DONE;
                        pready_q <= 1'b1;
                    end else begin
                        cnt_q   <= 2'(RD_LAT);
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (!psel_i) begin
                        state_q <= IDLE;
                        cnt_q   <= 2'd0;
                    end else begin
                        cnt_q <= cnt_q - 2'd1;
                        // Last wait cycle is exactly RD_LAT cycles after the strobe.
                        if (cnt_q == 2'd1) begin
                            prdata_q <= rdata_i;
                            state_q  <= DONE;
                            pready_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (!psel_i || penable_i) begin
                        state_q   <= IDLE;
                        pready_q  <= 1'b0;
                        pslverr_q <= 1'b0;
                        prdata_q  <= 16'd0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign prdata_o  = {16'd0, prdata_q};
    assign pready_o  = pready_q;
    assign pslverr_o = pslverr_q;
    assign acc_en_o  = acc_en_q;
    assign wr_en_o   = wr_en_q;
    assign addr_o    = addr_q;
    assign wdata_o   = wdata_q;

endmodule

// File: tb/tb_apb_reg_bridge.sv
// Four bridges (RD_LAT 0..3) share one APB master; each has its own register stub.
// Expected strobes and responses are queued at issue and popped by a negedge monitor.
module tb_apb_reg_bridge;

    localparam int N = 4;

    typedef struct {
        int          inst;
        logic        wr;
        logic [2:0]  addr;
        logic [15:0] wdata;
    } stb_t;

    typedef struct {
        int          inst;
        int          cyc;
        logic [31:0] data;
        logic        err;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rstn;
    logic        psel, penable, pwrite;
    logic [4:0]  paddr;
    logic [31:0] pwdata;

    logic [N-1:0] pready, pslverr, acc_en, wr_en, acc_prev;
    logic [31:0]  prdata [N];
    logic [2:0]   addr   [N];
    logic [15:0]  wdata  [N];
    logic [15:0]  rdata  [N];

    stb_t stb_q[$];
    rsp_t rsp_q[$];
    int   cyc = 0;
    int   setup_cyc = 0;
    int   n_tot = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < N; g++) begin : g_dut
        logic [15:0] regs [8] = '{16'h1111, 16'h2222, 16'h3333, 16'h0155,
                                  16'h5555, 16'h6666, 16'hBAD0, 16'hBAD1};
        logic [2:0]  since_q = 3'd7;
        logic [2:0]  age;

        // Read data is only valid exactly RD_LAT cycles after the strobe.
        assign age      = acc_en[g] ? 3'd0 : since_q;
        assign rdata[g] = (age == 3'(g)) ? regs[addr[g]] : 16'hDEAD;

        always @(posedge clk) begin
            if (acc_en[g]) since_q <= 3'd1;
            else if (since_q != 3'd7) since_q <= since_q + 3'd1;
            if (acc_en[g] && wr_en[g]) regs[addr[g]] <= wdata[g];
        end

        apb_reg_bridge #(.ADDR_W(5), .NUM_REGS(6), .RD_LAT(g)) u_dut (
            .clk_i    (clk),
            .rstn_i   (rstn),
            .psel_i   (psel),
            .penable_i(penable),
            .pwrite_i (pwrite),
            .paddr_i  (paddr),
            .pwdata_i (pwdata),
            .prdata_o (prdata[g]),
            .pready_o (pready[g]),
            .pslverr_o(pslverr[g]),
            .acc_en_o (acc_en[g]),
            .wr_en_o  (wr_en[g]),
            .addr_o   (addr[g]),
            .wdata_o  (wdata[g]),
            .rdata_i  (rdata[g])
        );
    end

    task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
        n_tot++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int find_stb(int inst);
        for (int k = 0; k < stb_q.size(); k++) if (stb_q[k].inst == inst) return k;
        return -1;
    endfunction

    function automatic int find_rsp(int inst);
        for (int k = 0; k < rsp_q.size(); k++) if (rsp_q[k].inst == inst) return k;
        return -1;
    endfunction

    // Monitor: pops expectations whenever a DUT strobes or completes.
    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            int k;
            if (acc_en[i]) begin
                check($sformatf("strobe_single%0d", i), 64'(acc_prev[i]), 64'd0);
                k = find_stb(i);
                if (k < 0) begin
                    check($sformatf("strobe_unexp%0d", i), 64'(acc_en[i]), 64'd0);
                end else begin
                    check($sformatf("strobe_wr%0d", i), 64'(wr_en[i]), 64'(stb_q[k].wr));
                    check($sformatf("strobe_addr%0d", i), 64'(addr[i]), 64'(stb_q[k].addr));
                    check($sformatf("strobe_wdata%0d", i), 64'(wdata[i]), 64'(stb_q[k].wdata));
                    stb_q.delete(k);
                end
            end
            if (pready[i]) begin
                k = find_rsp(i);
                if (k < 0) begin
                    check($sformatf("rsp_unexp%0d", i), 64'(pready[i]), 64'd0);
                end else begin
                    check($sformatf("rsp_cyc%0d", i), 64'(cyc), 64'(rsp_q[k].cyc));
                    check($sformatf("rsp_data%0d", i), 64'(prdata[i]), 64'(rsp_q[k].data));
                    check($sformatf("rsp_err%0d", i), 64'(pslverr[i]), 64'(rsp_q[k].err));
                    rsp_q.delete(k);
                end
            end else begin
                check($sformatf("prdata_idle%0d", i), 64'(prdata[i]), 64'd0);
                check($sformatf("pslverr_idle%0d", i), 64'(pslverr[i]), 64'd0);
            end
        end
        acc_prev <= acc_en;
    end

    task automatic setup(logic w, logic [4:0] a, logic [31:0] d);
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = d;
        setup_cyc = cyc;
    endtask

    task automatic access(int n);
        repeat (n) begin @(posedge clk); #1; penable = 1'b1; end
    endtask

    task automatic idle(int n);
        repeat (n) begin @(posedge clk); #1; psel = 1'b0; penable = 1'b0; end
    endtask

    task automatic wr(logic [4:0] a, logic [31:0] d);
        setup(1'b1, a, d);
        for (int i = 0; i < N; i++) begin
            stb_q.push_back('{i, 1'b1, a[4:2], d[15:0]});
            rsp_q.push_back('{i, setup_cyc + 2, 32'd0, 1'b0});
        end
        access(2);
    endtask

    task automatic rd(logic [4:0] a, logic [15:0] v);
        setup(1'b0, a, 32'd0);
        for (int i = 0; i < N; i++) begin
            stb_q.push_back('{i, 1'b0, a[4:2], 16'd0});
            rsp_q.push_back('{i, setup_cyc + 2 + i, {16'd0, v}, 1'b0});
        end
        access(5);
    endtask

    task automatic er(logic [4:0] a);
        setup(1'b0, a, 32'hFFFF_FFFF);
        for (int i = 0; i < N; i++) rsp_q.push_back('{i, setup_cyc + 1, 32'd0, 1'b1});
        access(1);
    endtask

    task automatic check_zero(string nm);
        for (int i = 0; i < N; i++)
            check($sformatf("%s%0d", nm, i),
                  {9'd0, prdata[i], pready[i], pslverr[i], acc_en[i], wr_en[i], addr[i], wdata[i]},
                  64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = 5'd0; pwdata = 32'd0;
        acc_prev = '0;
        #3;
        check_zero("reset_state");
        @(negedge clk); #2; rstn = 1'b1;

        wr(5'h08, 32'hABCD_03FF);
        rd(5'h0C, 16'h0155);
        rd(5'h08, 16'h03FF);
        er(5'h18);
        er(5'h05);
        er(5'h1C);
        wr(5'h04, 32'h0000_1234);
        rd(5'h04, 16'h1234);
        rd(5'h14, 16'h6666);
        idle(1);

        // Access phase without setup must be ignored.
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 5'h00; pwdata = 32'h0000_9999;
        idle(2);

        // Abort: psel drops two cycles after setup; only RD_LAT=0 has completed by then.
        setup(1'b0, 5'h00, 32'd0);
        for (int i = 0; i < N; i++) stb_q.push_back('{i, 1'b0, 3'd0, 16'd0});
        rsp_q.push_back('{0, setup_cyc + 2, 32'h0000_1111, 1'b0});
        access(1);
        idle(2);
        rd(5'h00, 16'h1111);

        // Reset asserted while the write strobe is high.
        setup(1'b1, 5'h00, 32'h0000_7777);
        for (int i = 0; i < N; i++) stb_q.push_back('{i, 1'b1, 3'd0, 16'h7777});
        @(posedge clk); #1; penable = 1'b1;
        @(negedge clk); #2;
        rstn = 1'b0; psel = 1'b0; penable = 1'b0;
        #1;
        check_zero("midreset");
        @(negedge clk); #2; rstn = 1'b1;
        rd(5'h00, 16'h1111);
        wr(5'h14, 32'h0000_00A5);
        rd(5'h14, 16'h00A5);

        idle(4);
        check("stb_q_empty", 64'(stb_q.size()), 64'd0);
        check("rsp_q_empty", 64'(rsp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
